// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART link (receiver and transmitter):
//            receiver state encodings, data width and serial line levels.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Payload bits per frame (8N1 framing).
    localparam int UART_DATA_BITS = 8;

    // Serial line levels.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        s_idle    = 3'd0,
        s_start   = 3'd1,
        s_receive = 3'd2,
        s_stop    = 3'd3,
        s_break   = 3'd4
    } rx_state_t;

    // Mid-bit offset H = (CLKS_PER_BIT-1)/2, used to re-check the start bit
    // at its centre before committing to a frame.
    function automatic logic [15:0] mid_bit_offset(input int clks_per_bit);
        return 16'((clks_per_bit - 1) / 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_synchronizer
// Purpose  : Two-flop synchroniser for the asynchronous serial input. Resets
//            to the idle line level so a reset never looks like a start bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_synchronizer
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two-stage capture of the raw line into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= LINE_IDLE;
            sync_out <= LINE_IDLE;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : 8N1 UART receiver. Samples the synchronised line at mid-bit,
//            validates start and stop bits and presents each good byte with
//            a one-cycle valid pulse; a low stop bit gives a one-cycle frame
//            error pulse and the receiver then waits for the line to return
//            high before looking for another start bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
)
(
    input  logic                      i_CLK,
    input  logic                      i_RESET,
    input  logic                      i_RX,
    output logic [UART_DATA_BITS-1:0] o_DATA_OUT,
    output logic                      o_DATA_VALID,
    output logic                      o_FRAME_ERROR,
    output logic                      o_RX_BUSY
);

    // Last baud count of a bit period and the mid-bit offset.
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF      = mid_bit_offset(CLKS_PER_BIT);
    localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      rx_sync;

    rx_state_t                 state;
    rx_state_t                 state_next;
    logic [15:0]               baud_cnt;
    logic [15:0]               baud_next;
    logic [2:0]                bit_cnt;
    logic [2:0]                bit_next;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] shift_next;
    logic [UART_DATA_BITS-1:0] data_next;
    logic                      valid_next;
    logic                      ferr_next;
    logic                      busy_next;

    uart_rx_synchronizer u_sync (
        .clk      (i_CLK),
        .rst      (i_RESET),
        .async_in (i_RX),
        .sync_out (rx_sync)
    );

    // State, counters, shift register and output registers.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state         <= s_idle;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            o_DATA_OUT    <= '0;
            o_DATA_VALID  <= 1'b0;
            o_FRAME_ERROR <= 1'b0;
            o_RX_BUSY     <= 1'b0;
        end else begin
            state         <= state_next;
            baud_cnt      <= baud_next;
            bit_cnt       <= bit_next;
            shift_reg     <= shift_next;
            o_DATA_OUT    <= data_next;
            o_DATA_VALID  <= valid_next;
            o_FRAME_ERROR <= ferr_next;
            o_RX_BUSY     <= busy_next;
        end
    end

    // Next-state and datapath decisions, all taken on the synchronised line.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        data_next  = o_DATA_OUT;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            s_idle: begin
                baud_next = '0;
                if (rx_sync == LINE_START) begin
                    // This cycle is start-bit sample 0.
                    bit_next = '0;
                    if (HALF == 16'd0) begin
                        // Mid-bit is sample 0 itself: accept immediately.
                        state_next = s_receive;
                        baud_next  = '0;
                    end else begin
                        state_next = s_start;
                        baud_next  = 16'd1;
                    end
                end
            end

            s_start: begin
                if (baud_cnt == HALF) begin
                    baud_next = '0;
                    bit_next  = '0;
                    if (rx_sync == LINE_START) begin
                        state_next = s_receive;
                    end else begin
                        // Glitch shorter than half a bit: ignore it.
                        state_next = s_idle;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end

            s_receive: begin
                if (baud_cnt == BAUD_LAST) begin
                    // LSB arrives first, so shift in from the top.
                    shift_next = {rx_sync, shift_reg[UART_DATA_BITS-1:1]};
                    baud_next  = '0;
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = s_stop;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end

            s_stop: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (rx_sync == LINE_STOP) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = s_idle;
                    end else begin
                        // Held output byte is left untouched on a bad frame.
                        ferr_next  = 1'b1;
                        state_next = s_break;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end

            s_break: begin
                // A line held low must not be decoded as repeated frames.
                baud_next = '0;
                if (rx_sync == LINE_IDLE) begin
                    state_next = s_idle;
                end
            end

            default: begin
                state_next = s_idle;
                baud_next  = '0;
            end
        endcase

        // Busy is registered alongside the state it reflects.
        busy_next = (state_next != s_idle);
    end

endmodule
`default_nettype wire
